// File: rtl/key_event_sequencer_if.sv
// Signal bundle between the PS/2 receiver, scancode converter, character consumer and the sequencer.
interface key_event_sequencer_if;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic [7:0] scancode;
   logic       push_down;
   logic       push_up;
   logic [7:0] ascii_in;
   logic [7:0] out_char;
   logic       out_valid;
   logic       out_ready;
   logic       clr_err;
   logic       overrun;
   logic       overflow;

   modport master (
      output rx_byte, rx_valid, ascii_in, out_ready, clr_err,
      input  scancode, push_down, push_up, out_char, out_valid, overrun, overflow
   );

   modport slave (
      input  rx_byte, rx_valid, ascii_in, out_ready, clr_err,
      output scancode, push_down, push_up, out_char, out_valid, overrun, overflow
   );
endinterface

// File: rtl/key_event_sequencer.sv
// PS/2 scancode sequencer: decodes make/break/extended prefixes, pulses the converter,
// captures its ASCII result after ROM_LAT cycles and queues printable characters in a FWFT FIFO.
//
// state   | meaning
// IDLE    | waiting for a new scancode or prefix byte
// BRK     | 0xF0 seen, next byte is a released key
// EXT     | 0xE0 seen, extended key is swallowed
// EXT_BRK | 0xE0 0xF0 seen, next byte is swallowed
// ISSUE   | push_down or push_up is high this cycle
// WAIT    | converter ROM latency
// CAPT    | sample ascii_in, enqueue if printable
module key_event_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int ROM_LAT    = 2
) (
   input logic                 clk,
   input logic                 reset,
   key_event_sequencer_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = (ROM_LAT < 2) ? 1 : $clog2(ROM_LAT);

   typedef enum logic [2:0] {IDLE, BRK, EXT, EXT_BRK, ISSUE, WAIT, CAPT} state_t;

   state_t         state, state_nxt;
   logic [7:0]     scan_nxt;
   logic           is_make, make_nxt;
   logic [CW-1:0]  cnt, cnt_nxt;
   logic           capt_write;
   logic           busy;
   logic           modifier;

   logic [7:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [AW:0]    count;
   logic           full, pop, wr_ok, drop;

   assign modifier = (bus.scancode == 8'h12) || (bus.scancode == 8'h59) ||
                     (bus.scancode == 8'h58) || (bus.scancode == 8'h0E);
   assign busy     = (state == ISSUE) || (state == WAIT) || (state == CAPT);

   always_comb begin
      state_nxt  = state;
      scan_nxt   = bus.scancode;
      make_nxt   = is_make;
      cnt_nxt    = cnt;
      capt_write = 1'b0;
      case (state)
         IDLE: if (bus.rx_valid) begin
            if (bus.rx_byte == 8'hF0)      state_nxt = BRK;
            else if (bus.rx_byte == 8'hE0) state_nxt = EXT;
            else begin
               scan_nxt  = bus.rx_byte;
               make_nxt  = 1'b1;
               state_nxt = ISSUE;
            end
         end
         BRK: if (bus.rx_valid) begin
            scan_nxt  = bus.rx_byte;
            make_nxt  = 1'b0;
            state_nxt = ISSUE;
         end
         EXT: if (bus.rx_valid) state_nxt = (bus.rx_byte == 8'hF0) ? EXT_BRK : IDLE;
         EXT_BRK: if (bus.rx_valid) state_nxt = IDLE;
         ISSUE: begin
            if (!is_make)         state_nxt = IDLE;
            else if (ROM_LAT < 2) state_nxt = CAPT;
            else begin
               state_nxt = WAIT;
               cnt_nxt   = CW'(ROM_LAT - 1);
            end
         end
         WAIT: begin
            cnt_nxt = cnt - 1'b1;
            if (cnt <= CW'(1)) state_nxt = CAPT;
         end
         CAPT: begin
            capt_write = (bus.ascii_in != 8'h00) && !modifier;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pulses are registered from the next state so they line up with ISSUE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         bus.scancode  <= 8'h00;
         is_make       <= 1'b0;
         cnt           <= '0;
         bus.push_down <= 1'b0;
         bus.push_up   <= 1'b0;
      end else begin
         state         <= state_nxt;
         bus.scancode  <= scan_nxt;
         is_make       <= make_nxt;
         cnt           <= cnt_nxt;
         bus.push_down <= (state_nxt == ISSUE) && make_nxt;
         bus.push_up   <= (state_nxt == ISSUE) && !make_nxt;
      end
   end

   assign full  = (count == (AW+1)'(FIFO_DEPTH));
   assign pop   = (count != '0) && bus.out_ready;
   assign wr_ok = capt_write && (!full || pop);
   assign drop  = capt_write && full && !pop;

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= bus.ascii_in;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         if (wr_ok && !pop)      count <= count + 1'b1;
         else if (pop && !wr_ok) count <= count - 1'b1;
      end
   end

   assign bus.out_valid = (count != '0);
   assign bus.out_char  = (count != '0) ? mem[rd_ptr] : 8'h00;

   // A set event in the same cycle as clr_err keeps the flag high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.overrun  <= 1'b0;
         bus.overflow <= 1'b0;
      end else begin
         if (bus.rx_valid && busy) bus.overrun <= 1'b1;
         else if (bus.clr_err)     bus.overrun <= 1'b0;
         if (drop)                 bus.overflow <= 1'b1;
         else if (bus.clr_err)     bus.overflow <= 1'b0;
      end
   end
endmodule

// File: tb/tb_key_event_sequencer.sv
// Randomized bench for key_event_sequencer against an event-level keyboard model.
module tb_key_event_sequencer;
   localparam int DEPTH = 4;
   localparam int LAT   = 2;

   logic clk;
   logic reset;
   key_event_sequencer_if bus();

   key_event_sequencer #(.FIFO_DEPTH(DEPTH), .ROM_LAT(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [7:0] lut(input logic [7:0] s);
      case (s)
         8'h1C:   return 8'h61;
         8'h1B:   return 8'h73;
         8'h23:   return 8'h64;
         8'h12:   return 8'h53;
         8'h59:   return 8'h54;
         8'h58:   return 8'h55;
         8'h0E:   return 8'h60;
         default: return (s[3:0] == 4'h0) ? 8'h00 : {1'b0, s[6:0]};
      endcase
   endfunction

   function automatic bit is_mod(input logic [7:0] s);
      return (s == 8'h12) || (s == 8'h59) || (s == 8'h58) || (s == 8'h0E);
   endfunction

   // Converter: result appears exactly LAT cycles after the push_down pulse.
   logic [7:0] pipe [LAT];
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LAT; i++) pipe[i] <= 8'h00;
      end else begin
         pipe[0] <= bus.push_down ? lut(bus.scancode) : 8'h00;
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
   end
   assign bus.ascii_in = pipe[LAT-1];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model: prefix context, remaining busy cycles of the current event, expected outputs.
   int         m_prefix;
   int         m_busy;
   bit         m_make;
   logic [7:0] m_scan;
   bit         m_pd, m_pu, m_ovr, m_ovf;
   logic [7:0] q[$];

   task automatic model_reset();
      m_prefix = 0;
      m_busy   = 0;
      m_make   = 0;
      m_scan   = 8'h00;
      m_pd     = 0;
      m_pu     = 0;
      m_ovr    = 0;
      m_ovf    = 0;
      q.delete();
   endtask

   task automatic model_step();
      bit         full, pop, wr, ovr_set, ovf_set;
      logic [7:0] ch;
      full    = (q.size() == DEPTH);
      pop     = (q.size() != 0) && bus.out_ready;
      ovr_set = bus.rx_valid && (m_busy > 0);
      ovf_set = 0;
      wr      = 0;
      ch      = lut(m_scan);
      if (m_busy == 1 && m_make && ch != 8'h00 && !is_mod(m_scan)) begin
         if (full && !pop) ovf_set = 1;
         else              wr = 1;
      end
      if (pop) void'(q.pop_front());
      if (wr)  q.push_back(ch);
      m_pd = 0;
      m_pu = 0;
      if (m_busy > 0) m_busy--;
      else if (bus.rx_valid) begin
         case (m_prefix)
            0: begin
               if (bus.rx_byte == 8'hF0)      m_prefix = 1;
               else if (bus.rx_byte == 8'hE0) m_prefix = 2;
               else begin
                  m_scan = bus.rx_byte;
                  m_make = 1;
                  m_busy = LAT + 1;
                  m_pd   = 1;
               end
            end
            1: begin
               m_scan   = bus.rx_byte;
               m_make   = 0;
               m_busy   = 1;
               m_pu     = 1;
               m_prefix = 0;
            end
            2: m_prefix = (bus.rx_byte == 8'hF0) ? 3 : 0;
            default: m_prefix = 0;
         endcase
      end
      if (ovr_set)          m_ovr = 1;
      else if (bus.clr_err) m_ovr = 0;
      if (ovf_set)          m_ovf = 1;
      else if (bus.clr_err) m_ovf = 0;
   endtask

   task automatic check_all();
      check_val("push_down", 32'(bus.push_down), 32'(m_pd));
      check_val("push_up",   32'(bus.push_up),   32'(m_pu));
      check_val("scancode",  32'(bus.scancode),  32'(m_scan));
      check_val("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      check_val("out_char",  32'(bus.out_char),  32'((q.size() != 0) ? q[0] : 8'h00));
      check_val("overrun",   32'(bus.overrun),   32'(m_ovr));
      check_val("overflow",  32'(bus.overflow),  32'(m_ovf));
   endtask

   function automatic logic [7:0] pick_byte();
      case ($urandom % 10)
         0, 1:    return 8'hF0;
         2:       return 8'hE0;
         3:       return 8'h12;
         4:       return 8'h59;
         5:       return 8'h1C;
         6:       return 8'h1B;
         7:       return 8'h23;
         default: return 8'($urandom % 256);
      endcase
   endfunction

   initial begin
      reset         = 1'b1;
      bus.rx_byte   = 8'h00;
      bus.rx_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.clr_err   = 1'b0;
      model_reset();
      #1 check_all();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if ($urandom % 150 == 0 || (m_busy > 1 && $urandom % 40 == 0)) begin
            reset        = 1'b1;
            bus.rx_valid = 1'b0;
            #1;
            model_reset();
            check_all();
            @(posedge clk);
            @(negedge clk);
            check_all();
            reset = 1'b0;
         end else begin
            bus.rx_valid  = ($urandom % 2 == 0);
            bus.rx_byte   = bus.rx_valid ? pick_byte() : 8'($urandom % 256);
            bus.out_ready = (cyc < 1500) ? ($urandom % 6 == 0) : ($urandom % 2 == 0);
            bus.clr_err   = ($urandom % 40 == 0);
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_all();
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
